path_replay_ctrl: RTL and testbench

- Sequences playback of a solved maze path once the solver reports Done.
- Reads 2-bit direction codes from the solver's path memory, one entry per step (synchronous RAM, 1-cycle read latency).
- Converts each code into an absolute {row,col} position and presents it on Move[7:0] with a valid/ready handshake.
- Raises The_End after the last step; raises Fail if the path would leave the grid.

---
 rtl/maze_pkg.sv | 31 +++
 rtl/maze_step_calc.sv | 48 ++++
 rtl/path_replay_ctrl.sv | 170 +++++++++++++++++
 tb/tb_path_replay_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// ---------------------------------------------------------------------------
// maze_pkg : grid geometry, direction codes and replay FSM state encoding
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package maze_pkg;

  localparam int GRID_DIM = 16;
  localparam int COORD_W  = 4;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
`ifdef PATH_REPLAY_PACE_EN
    , ST_PACE  = 3'd6
`endif
  } replay_state_t;

endpackage

`default_nettype wire

// File: rtl/maze_step_calc.sv
// ---------------------------------------------------------------------------
// maze_step_calc : one grid step from {row,col} in direction dir; flags off-grid
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module maze_step_calc
  import maze_pkg::*;
(
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic [1:0]         dir,
  output logic [COORD_W-1:0] next_row,
  output logic [COORD_W-1:0] next_col,
  output logic               off_grid
);

  localparam logic [COORD_W-1:0] c_edge_max = COORD_W'(GRID_DIM - 1);
  localparam logic [COORD_W-1:0] c_one      = COORD_W'(1);

  // An off-grid step leaves the coordinates untouched.
  always_comb begin
    next_row = row;
    next_col = col;
    off_grid = 1'b0;
    case (dir)
      DIR_UP: begin
        if (row == '0) off_grid = 1'b1;
        else           next_row = row - c_one;
      end
      DIR_RIGHT: begin
        if (col == c_edge_max) off_grid = 1'b1;
        else                   next_col = col + c_one;
      end
      DIR_LEFT: begin
        if (col == '0) off_grid = 1'b1;
        else           next_col = col - c_one;
      end
      default: begin
        if (row == c_edge_max) off_grid = 1'b1;
        else                   next_row = row + c_one;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/path_replay_ctrl.sv
// ---------------------------------------------------------------------------
// path_replay_ctrl : replays a solved maze path as absolute {row,col} moves.
// Optional inter-move pacing when PATH_REPLAY_PACE_EN is defined.
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module path_replay_ctrl
  import maze_pkg::*;
#(
  parameter int START_ROW   = 0,
  parameter int START_COL   = 0,
  parameter int PACE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start_Play,
  input  logic       Solve_Done,
  input  logic [8:0] Path_Len,
  output logic       Rd_En,
  output logic [7:0] Rd_Addr,
  input  logic [1:0] Rd_Data,
  input  logic       Move_Ready,
  output logic       Move_Valid,
  output logic [7:0] Move,
  output logic       Busy,
  output logic       The_End,
  output logic       Fail
);

  localparam logic [7:0] c_start_pos = {COORD_W'(START_ROW), COORD_W'(START_COL)};

  replay_state_t state_q, state_d;
  logic [7:0]    pos_q, pos_d;
  logic [7:0]    idx_q, idx_d;
  logic [8:0]    len_q, len_d;
  logic          the_end_q, the_end_d;
  logic          fail_q, fail_d;

  logic [COORD_W-1:0] next_row;
  logic [COORD_W-1:0] next_col;
  logic               off_grid;
  logic               last_move;

`ifdef PATH_REPLAY_PACE_EN
  localparam logic [7:0] c_pace = 8'(PACE_CYCLES);
  logic [7:0] pace_cnt_q, pace_cnt_d;
`endif

  maze_step_calc u_step (
    .row      (pos_q[7:4]),
    .col      (pos_q[3:0]),
    .dir      (Rd_Data),
    .next_row (next_row),
    .next_col (next_col),
    .off_grid (off_grid)
  );

  // 9-bit compare so a 256-entry path ends after index 255.
  assign last_move = ({1'b0, idx_q} + 9'd1) == len_q;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    idx_d     = idx_q;
    len_d     = len_q;
    the_end_d = the_end_q;
    fail_d    = fail_q;
`ifdef PATH_REPLAY_PACE_EN
    pace_cnt_d = pace_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start_Play && Solve_Done) begin
          the_end_d = 1'b0;
          fail_d    = 1'b0;
          pos_d     = c_start_pos;
          idx_d     = '0;
          len_d     = Path_Len;
          if (Path_Len == 9'd0) begin
            state_d   = ST_DONE;
            the_end_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH:   state_d = ST_WAIT_RD;
      ST_WAIT_RD: begin
        if (off_grid) begin
          state_d = ST_ERR;
          fail_d  = 1'b1;
        end else begin
          pos_d   = {next_row, next_col};
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (Move_Ready) begin
          idx_d = idx_q + 8'd1;
          if (last_move) begin
            state_d   = ST_DONE;
            the_end_d = 1'b1;
          end else begin
`ifdef PATH_REPLAY_PACE_EN
            if (c_pace == 8'd0) begin
              state_d = ST_FETCH;
            end else begin
              state_d    = ST_PACE;
              pace_cnt_d = c_pace;
            end
`else
            state_d = ST_FETCH;
`endif
          end
        end
      end
`ifdef PATH_REPLAY_PACE_EN
      ST_PACE: begin
        if (pace_cnt_q <= 8'd1) state_d = ST_FETCH;
        else                    pace_cnt_d = pace_cnt_q - 8'd1;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pos_q     <= c_start_pos;
      idx_q     <= '0;
      len_q     <= '0;
      the_end_q <= 1'b0;
      fail_q    <= 1'b0;
`ifdef PATH_REPLAY_PACE_EN
      pace_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      the_end_q <= the_end_d;
      fail_q    <= fail_d;
`ifdef PATH_REPLAY_PACE_EN
      pace_cnt_q <= pace_cnt_d;
`endif
    end
  end

  assign Rd_En      = (state_q == ST_FETCH);
  assign Rd_Addr    = idx_q;
  assign Move_Valid = (state_q == ST_PRESENT);
  assign Move       = pos_q;
  assign The_End    = the_end_q;
  assign Fail       = fail_q;
`ifdef PATH_REPLAY_PACE_EN
  assign Busy = (state_q == ST_FETCH) || (state_q == ST_WAIT_RD) ||
                (state_q == ST_PRESENT) || (state_q == ST_PACE);
`else
  assign Busy = (state_q == ST_FETCH) || (state_q == ST_WAIT_RD) ||
                (state_q == ST_PRESENT);
`endif

endmodule

`default_nettype wire

// File: tb/tb_path_replay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_path_replay_ctrl : directed self-checking bench for path_replay_ctrl
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_path_replay_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       Start_Play;
  logic       Solve_Done;
  logic [8:0] Path_Len;
  logic       Rd_En;
  logic [7:0] Rd_Addr;
  logic [1:0] Rd_Data;
  logic       Move_Ready;
  logic       Move_Valid;
  logic [7:0] Move;
  logic       Busy;
  logic       The_End;
  logic       Fail;

  logic [1:0] mem [256];

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] moves[$];
  int rd_cnt, valid_cycles, first_valid, hold_cnt, end_cyc, timed_out;
  logic busy_seen, flag_at_first;

  path_replay_ctrl #(.START_ROW(0), .START_COL(0), .PACE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .Start_Play (Start_Play),
    .Solve_Done (Solve_Done),
    .Path_Len   (Path_Len),
    .Rd_En      (Rd_En),
    .Rd_Addr    (Rd_Addr),
    .Rd_Data    (Rd_Data),
    .Move_Ready (Move_Ready),
    .Move_Valid (Move_Valid),
    .Move       (Move),
    .Busy       (Busy),
    .The_End    (The_End),
    .Fail       (Fail)
  );

  always #5 clk = ~clk;

  // Path memory: one-cycle read latency.
  always @(posedge clk) begin
    if (Rd_En) Rd_Data <= mem[Rd_Addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mv(input int i);
    logic [7:0] r;
    r = (i < moves.size()) ? moves[i] : 8'hxx;
    return r;
  endfunction

  // Called at a negedge with the DUT idle. Pulses Start_Play, then observes
  // every negedge until The_End/Fail appear or the budget runs out.
  task automatic play(input int stall_move, input int stall_len, input logic [7:0] stall_exp,
                      input int disturb_at, input int budget);
    int cyc, nmv, stalled;
    moves.delete();
    rd_cnt = 0; valid_cycles = 0; first_valid = -1; hold_cnt = 0; end_cyc = -1;
    timed_out = 0; busy_seen = 1'b0; flag_at_first = 1'b0;
    nmv = 0; stalled = 0;
    Start_Play = 1'b1;
    Move_Ready = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (cyc < budget) begin
      Start_Play = (disturb_at >= 0) && (cyc >= disturb_at) && (cyc < disturb_at + 3);
      if (disturb_at >= 0 && cyc == disturb_at) begin
        Solve_Done = 1'b0;
        Path_Len   = 9'd5;
      end
      if (Rd_En) rd_cnt++;
      if (Busy) busy_seen = 1'b1;
      if (Move_Valid) begin
        valid_cycles++;
        if (first_valid < 0) begin
          first_valid   = cyc;
          flag_at_first = The_End | Fail;
        end
        if (nmv == stall_move && stalled < stall_len) begin
          Move_Ready = 1'b0;
          stalled++;
          if (Move == stall_exp) hold_cnt++;
        end else begin
          Move_Ready = 1'b1;
          moves.push_back(Move);
          nmv++;
        end
      end else begin
        Move_Ready = 1'b1;
      end
      if (The_End || Fail) begin
        end_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= budget) timed_out = 1;
    Start_Play = 1'b0;
    check("no_timeout", timed_out, 0);
  endtask

  initial begin
    rst        = 1'b0;
    Start_Play = 1'b0;
    Solve_Done = 1'b1;
    Path_Len   = 9'd0;
    Move_Ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 2'b01;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_move",    Move, 8'h00);
    check("rst_busy",    Busy, 0);
    check("rst_rd_en",   Rd_En, 0);
    check("rst_valid",   Move_Valid, 0);
    check("rst_the_end", The_End, 0);
    check("rst_fail",    Fail, 0);
    check("rst_rd_addr", Rd_Addr, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    // Basic 3-step path: right, down, right
    mem[0] = 2'b01; mem[1] = 2'b11; mem[2] = 2'b01;
    Path_Len = 9'd3;
    play(-1, 0, 8'h00, -1, 40);
    check("t1_count",   moves.size(), 3);
    check("t1_move0",   mv(0), 8'h01);
    check("t1_move1",   mv(1), 8'h11);
    check("t1_move2",   mv(2), 8'h12);
    check("t1_latency", first_valid, 3);
    check("t1_the_end", The_End, 1);
    check("t1_fail",    Fail, 0);
    check("t1_rd_cnt",  rd_cnt, 3);
    check("t1_busy_at_end", Busy, 0);
    @(negedge clk);
    check("t1_the_end_held", The_End, 1);

    // Same path with a 5-cycle stall on the second move
    play(1, 5, 8'h11, -1, 40);
    check("t2_flags_cleared", flag_at_first, 0);
    check("t2_hold_cycles",   hold_cnt, 5);
    check("t2_valid_cycles",  valid_cycles, 8);
    check("t2_move0",         mv(0), 8'h01);
    check("t2_move1",         mv(1), 8'h11);
    check("t2_move2",         mv(2), 8'h12);
    check("t2_the_end",       The_End, 1);
    @(negedge clk);

    // Right then up from row 0: second step leaves the grid
    mem[0] = 2'b01; mem[1] = 2'b00;
    Path_Len = 9'd2;
    play(-1, 0, 8'h00, -1, 40);
    check("t3_fail",         Fail, 1);
    check("t3_the_end",      The_End, 0);
    check("t3_move_held",    Move, 8'h01);
    check("t3_valid_cycles", valid_cycles, 1);
    check("t3_count",        moves.size(), 1);
    @(negedge clk);
    check("t3_fail_held", Fail, 1);

    // Every direction: down, down, right, right, up, left
    mem[0] = 2'b11; mem[1] = 2'b11; mem[2] = 2'b01;
    mem[3] = 2'b01; mem[4] = 2'b00; mem[5] = 2'b10;
    Path_Len = 9'd6;
    play(-1, 0, 8'h00, -1, 60);
    check("t4_flags_cleared", flag_at_first, 0);
    check("t4_count", moves.size(), 6);
    check("t4_move0", mv(0), 8'h10);
    check("t4_move1", mv(1), 8'h20);
    check("t4_move2", mv(2), 8'h21);
    check("t4_move3", mv(3), 8'h22);
    check("t4_move4", mv(4), 8'h12);
    check("t4_move5", mv(5), 8'h11);
    check("t4_the_end", The_End, 1);
    @(negedge clk);

    // Bottom edge: 15 downs reach row 15, the 16th fails
    for (int i = 0; i < 16; i++) mem[i] = 2'b11;
    Path_Len = 9'd16;
    play(-1, 0, 8'h00, -1, 100);
    check("t5_count",   moves.size(), 15);
    check("t5_last",    mv(14), 8'hF0);
    check("t5_fail",    Fail, 1);
    check("t5_the_end", The_End, 0);
    check("t5_move",    Move, 8'hF0);
    @(negedge clk);

    // Empty path
    Path_Len = 9'd0;
    play(-1, 0, 8'h00, -1, 10);
    check("t6_rd_cnt",  rd_cnt, 0);
    check("t6_valid",   valid_cycles, 0);
    check("t6_the_end", The_End, 1);
    check("t6_end_cyc", end_cyc, 1);
    check("t6_busy",    busy_seen, 0);
    check("t6_fail",    Fail, 0);
    @(negedge clk);

    // Reset while the second move is presented
    mem[0] = 2'b01; mem[1] = 2'b11; mem[2] = 2'b01;
    Path_Len = 9'd3;
    Start_Play = 1'b1;
    Move_Ready = 1'b1;
    begin
      int  k;
      logic found;
      found = 1'b0;
      for (k = 0; k < 30 && !found; k++) begin
        @(negedge clk);
        Start_Play = 1'b0;
        if (Move_Valid && Move == 8'h11) begin
          Move_Ready = 1'b0;
          found = 1'b1;
        end
      end
      check("t7_reached_move2", found, 1);
    end
    rst = 1'b0;
    @(negedge clk);
    check("t7_move",  Move, 8'h00);
    check("t7_busy",  Busy, 0);
    check("t7_valid", Move_Valid, 0);
    check("t7_rd_en", Rd_En, 0);
    rst = 1'b1;
    Move_Ready = 1'b1;
    @(negedge clk);
    play(-1, 0, 8'h00, -1, 40);
    check("t7_replay_count", moves.size(), 3);
    check("t7_replay_move0", mv(0), 8'h01);
    check("t7_replay_move2", mv(2), 8'h12);
    @(negedge clk);

    // Start_Play without Solve_Done is ignored
    Solve_Done = 1'b0;
    Start_Play = 1'b1;
    @(negedge clk);
    Start_Play = 1'b0;
    begin
      int rd_seen, busy_cnt;
      rd_seen = 0; busy_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        if (Rd_En) rd_seen++;
        if (Busy) busy_cnt++;
        @(negedge clk);
      end
      check("t8_no_rd_en", rd_seen, 0);
      check("t8_no_busy",  busy_cnt, 0);
    end

    // Restart, Solve_Done drop and Path_Len change while busy: all ignored
    Solve_Done = 1'b1;
    mem[3] = 2'b01; mem[4] = 2'b01;
    play(-1, 0, 8'h00, 2, 40);
    check("t9_count",   moves.size(), 3);
    check("t9_move0",   mv(0), 8'h01);
    check("t9_move1",   mv(1), 8'h11);
    check("t9_move2",   mv(2), 8'h12);
    check("t9_rd_cnt",  rd_cnt, 3);
    check("t9_the_end", The_End, 1);
    Solve_Done = 1'b1;
    Path_Len   = 9'd0;
    @(negedge clk);

    // Full 256-entry path alternating right/left
    for (int i = 0; i < 256; i++) mem[i] = (i % 2 == 1) ? 2'b10 : 2'b01;
    Path_Len = 9'd256;
    play(-1, 0, 8'h00, -1, 1000);
    check("t10_count",   moves.size(), 256);
    check("t10_m254",    mv(254), 8'h01);
    check("t10_m255",    mv(255), 8'h00);
    check("t10_the_end", The_End, 1);
    check("t10_fail",    Fail, 0);
    check("t10_rd_cnt",  rd_cnt, 256);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
